mina_mem: RTL and testbench

Unified memory responder for the MINA2000 core: the far end of the core's IMEM and DMEM interfaces. It serves combinational instruction fetches and data loads from one shared RAM, commits byte-strobed stores on the clock edge, and decodes a small MMIO window. The MMIO window holds a buffered console output port with a valid/ready handshake, a free-running cycle counter, and a sticky TOHOST/halt register used by simulation and FPGA top levels.

---
 rtl/mina_mem_pkg.sv | 34 +++
 rtl/cons_fifo.sv | 47 ++++
 rtl/mina_mem.sv | 119 +++++++++++
 tb/tb_mina_mem.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mina_mem_pkg.sv
// Shared types for the MINA2000 memory responder: bus types, MMIO map and console status layout.
package mina_mem_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    localparam u32_t MMIO_BASE       = 32'hF000_0000;
    localparam u32_t CONS_DATA_OFF   = 32'h0;
    localparam u32_t CONS_STATUS_OFF = 32'h4;
    localparam u32_t CYCLE_OFF       = 32'h8;
    localparam u32_t TOHOST_OFF      = 32'hC;

    // Register select is the word index within the 16-byte MMIO window.
    typedef enum logic [1:0] {
        MMIO_CONS_DATA   = CONS_DATA_OFF[3:2],
        MMIO_CONS_STATUS = CONS_STATUS_OFF[3:2],
        MMIO_CYCLE       = CYCLE_OFF[3:2],
        MMIO_TOHOST      = TOHOST_OFF[3:2]
    } mmio_reg_e;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        overflow;
        logic        empty;
        logic        full;
    } cons_status_t;

    function automatic logic is_mmio(input u32_t addr);
        return (addr & ~32'hF) == MMIO_BASE;
    endfunction

endpackage

// File: rtl/cons_fifo.sv
// Byte FIFO for the console port; pointers carry an extra wrap bit to separate full from empty.
module cons_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mina_mem.sv
// Unified IMEM/DMEM responder: shared RAM with combinational reads, byte-strobed stores and an MMIO window.
module mina_mem
  import mina_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 16384,
  parameter int unsigned CONS_DEPTH = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wrdata,
  input  logic [3:0]  dmem_wrstb,
  output logic [31:0] dmem_rddata,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready,
  output logic        halt,
  output logic [31:0] tohost
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(CONS_DEPTH) + 1;

  u32_t              mem [MEM_WORDS];
  u32_t              cycle;
  logic              overflow;
  logic [IDX_W-1:0]  imem_idx;
  logic [IDX_W-1:0]  dmem_idx;
  logic              imem_ram_hit;
  logic              dmem_ram_hit;
  logic              dmem_mmio_hit;
  mmio_reg_e         mmio_sel;
  logic              cons_push;
  logic              cons_pop;
  logic              tohost_we;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  cons_status_t      status;
  logic              unused_addr_lsbs;

  assign imem_idx         = imem_addr[IDX_W+1:2];
  assign dmem_idx         = dmem_addr[IDX_W+1:2];
  assign imem_ram_hit     = (imem_addr >> (IDX_W + 2)) == 32'd0;
  assign dmem_ram_hit     = (dmem_addr >> (IDX_W + 2)) == 32'd0;
  assign dmem_mmio_hit    = is_mmio(dmem_addr);
  assign mmio_sel         = mmio_reg_e'(dmem_addr[3:2]);
  assign unused_addr_lsbs = ^{imem_addr[1:0], dmem_addr[1:0]};

  assign cons_pop  = cons_valid && cons_ready;
  assign cons_push = dmem_mmio_hit && (mmio_sel == MMIO_CONS_DATA) && dmem_wrstb[0];
  assign tohost_we = dmem_mmio_hit && (mmio_sel == MMIO_TOHOST) && (dmem_wrstb == 4'b1111) && !halt;

  assign imem_data = imem_ram_hit ? mem[imem_idx] : '0;

  // RAM writes are deliberately outside reset so a store during reset still lands.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (dmem_ram_hit && dmem_wrstb[i]) mem[dmem_idx][8*i +: 8] <= dmem_wrdata[8*i +: 8];
    end
  end

  cons_fifo #(
    .DEPTH (CONS_DEPTH)
  ) u_cons_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cons_push),
    .push_data (dmem_wrdata[7:0]),
    .pop       (cons_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cons_valid = !fifo_empty;
  assign cons_data  = fifo_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle    <= '0;
      overflow <= 1'b0;
      halt     <= 1'b0;
      tohost   <= '0;
    end else begin
      cycle <= cycle + 1'b1;
      if (cons_push && fifo_full && !cons_pop) overflow <= 1'b1;
      if (tohost_we) begin
        tohost <= dmem_wrdata;
        halt   <= 1'b1;
      end
    end
  end

  always_comb begin
    status          = '0;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.overflow = overflow;
    status.count    = 8'(fifo_count);
    dmem_rddata     = '0;
    if (dmem_ram_hit) begin
      dmem_rddata = mem[dmem_idx];
    end else if (dmem_mmio_hit) begin
      unique case (mmio_sel)
        MMIO_CONS_STATUS: dmem_rddata = status;
        MMIO_CYCLE:       dmem_rddata = cycle;
        MMIO_TOHOST:      dmem_rddata = tohost;
        default:          dmem_rddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mina_mem.sv
// Scoreboard bench for mina_mem: stimulus queues expectations, a negedge monitor compares them.
module tb_mina_mem;

    localparam int SEL_RD     = 0;
    localparam int SEL_IMEM   = 1;
    localparam int SEL_HALT   = 2;
    localparam int SEL_TOHOST = 3;
    localparam int SEL_VALID  = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wrdata;
    logic [3:0]  dmem_wrstb;
    logic [31:0] dmem_rddata;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        halt;
    logic [31:0] tohost;

    exp_t       exp_q[$];
    logic [7:0] cons_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mina_mem #(
        .MEM_WORDS  (16384),
        .CONS_DEPTH (8),
        .INIT_FILE  ("")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .dmem_addr   (dmem_addr),
        .dmem_wrdata (dmem_wrdata),
        .dmem_wrstb  (dmem_wrstb),
        .dmem_rddata (dmem_rddata),
        .cons_data   (cons_data),
        .cons_valid  (cons_valid),
        .cons_ready  (cons_ready),
        .halt        (halt),
        .tohost      (tohost)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] stb);
        dmem_addr   = addr;
        dmem_wrdata = wd;
        dmem_wrstb  = stb;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = val;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        logic [7:0]  eb;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_RD:     act = dmem_rddata;
                SEL_IMEM:   act = imem_data;
                SEL_HALT:   act = {31'd0, halt};
                SEL_TOHOST: act = tohost;
                default:    act = {31'd0, cons_valid};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        if (cons_valid && cons_ready) begin
            checks++;
            if (cons_q.size() == 0) begin
                errors++;
                $display("FAIL cons_unexpected: got %h expected no transfer", cons_data);
            end else begin
                eb = cons_q.pop_front();
                if (cons_data !== eb) begin
                    errors++;
                    $display("FAIL cons_byte: got %h expected %h", cons_data, eb);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        cons_ready = 1'b0;
        imem_addr  = '0;
        drive(32'h0, 32'h0, 4'h0);

        cyc();
        expect_val("rst_valid", SEL_VALID, 32'd0);
        expect_val("rst_halt", SEL_HALT, 32'd0);
        expect_val("rst_tohost", SEL_TOHOST, 32'd0);
        cyc(); rst_n = 1'b1; drive(32'hF000_0008, 32'h0, 4'h0);
        expect_val("cycle_zero", SEL_RD, 32'd0);
        cyc(); expect_val("cycle_one", SEL_RD, 32'd1);

        // byte-strobe merge
        cyc(); drive(32'h100, 32'hAABB_CCDD, 4'hF);
        cyc(); drive(32'h100, 32'h0000_1122, 4'h3);
        cyc(); drive(32'h100, 32'h0, 4'h0); imem_addr = 32'h100;
        expect_val("merge_rd", SEL_RD, 32'hAABB_1122);
        expect_val("merge_imem", SEL_IMEM, 32'hAABB_1122);
        cyc(); drive(32'h103, 32'h0, 4'h0);
        expect_val("unaligned_rd", SEL_RD, 32'hAABB_1122);

        // out-of-range store would alias word 0 if not dropped
        cyc(); drive(32'h0, 32'h0, 4'hF);
        cyc(); drive(32'h0010_0000, 32'hDEAD_BEEF, 4'hF); imem_addr = 32'h0010_0000;
        expect_val("oor_rd", SEL_RD, 32'd0);
        expect_val("oor_imem", SEL_IMEM, 32'd0);
        cyc(); drive(32'h0, 32'h0, 4'h0); imem_addr = 32'h0;
        expect_val("oor_dropped", SEL_RD, 32'd0);
        cyc(); drive(32'h8000_0000, 32'h0, 4'h0);
        expect_val("unmapped_rd", SEL_RD, 32'd0);
        cyc(); drive(32'hF000_0010, 32'h0, 4'h0);
        expect_val("mmio_hole_rd", SEL_RD, 32'd0);

        // read-during-write
        cyc(); drive(32'h40, 32'h0, 4'hF);
        cyc(); drive(32'h40, 32'h1234_5678, 4'hF); imem_addr = 32'h40;
        expect_val("rdw_old_rd", SEL_RD, 32'd0);
        expect_val("rdw_old_imem", SEL_IMEM, 32'd0);
        cyc(); drive(32'h40, 32'h0, 4'h0);
        expect_val("rdw_new_rd", SEL_RD, 32'h1234_5678);
        expect_val("rdw_new_imem", SEL_IMEM, 32'h1234_5678);

        // console overflow
        cyc(); drive(32'hF000_0004, 32'h0, 4'h0);
        expect_val("status_empty", SEL_RD, 32'h0000_0002);
        expect_val("valid_empty", SEL_VALID, 32'd0);
        for (int i = 0; i < 9; i++) begin
            cyc(); drive(32'hF000_0000, 32'h41 + i, 4'h1);
            if (i < 8) cons_q.push_back(8'(8'h41 + i));
            if (i == 0) expect_val("valid_before_push", SEL_VALID, 32'd0);
            if (i == 1) expect_val("valid_after_push", SEL_VALID, 32'd1);
        end
        cyc(); drive(32'hF000_0004, 32'h0, 4'h0);
        expect_val("status_overflow", SEL_RD, 32'h0000_0805);
        cyc(); drive(32'hF000_0000, 32'h0, 4'h0); cons_ready = 1'b1;
        expect_val("cons_data_reads0", SEL_RD, 32'd0);
        for (int i = 0; i < 7; i++) begin
            cyc(); drive(32'hF000_0004, 32'h0, 4'h0);
        end
        cyc(); cons_ready = 1'b0;
        expect_val("valid_drained", SEL_VALID, 32'd0);
        expect_val("status_drained", SEL_RD, 32'h0000_0006);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            cyc(); drive(32'hF000_0000, 32'h61 + i, 4'h1);
            cons_q.push_back(8'(8'h61 + i));
        end
        cyc(); drive(32'hF000_0000, 32'h50, 4'h1); cons_ready = 1'b1;
        cons_q.push_back(8'h50);
        cyc(); drive(32'hF000_0004, 32'h0, 4'h0); cons_ready = 1'b0;
        expect_val("status_pushpop", SEL_RD, 32'h0000_0805);
        for (int i = 0; i < 8; i++) begin
            cyc(); cons_ready = 1'b1;
        end
        cyc(); cons_ready = 1'b0;
        expect_val("valid_drained2", SEL_VALID, 32'd0);
        expect_val("status_drained2", SEL_RD, 32'h0000_0006);

        // TOHOST and halt
        cyc(); drive(32'hF000_000C, 32'h1, 4'h3);
        cyc(); drive(32'hF000_000C, 32'h0, 4'h0);
        expect_val("partial_halt", SEL_HALT, 32'd0);
        expect_val("partial_tohost", SEL_TOHOST, 32'd0);
        expect_val("partial_rd", SEL_RD, 32'd0);
        cyc(); drive(32'hF000_000C, 32'h1, 4'hF);
        cyc(); drive(32'hF000_000C, 32'h0, 4'h0);
        expect_val("halt_set", SEL_HALT, 32'd1);
        expect_val("tohost_set", SEL_TOHOST, 32'd1);
        expect_val("tohost_rd", SEL_RD, 32'd1);
        cyc(); drive(32'hF000_000C, 32'h5, 4'hF);
        cyc(); drive(32'hF000_000C, 32'h0, 4'h0);
        expect_val("tohost_sticky", SEL_TOHOST, 32'd1);
        expect_val("tohost_sticky_rd", SEL_RD, 32'd1);
        expect_val("halt_sticky", SEL_HALT, 32'd1);
        cyc(); drive(32'h100, 32'h0, 4'h0);
        expect_val("ram_after_halt", SEL_RD, 32'hAABB_1122);

        // reset mid-operation: RAM store commits, MMIO store is overridden
        cyc(); rst_n = 1'b0; drive(32'h200, 32'hCAFE_F00D, 4'hF);
        cyc(); drive(32'hF000_0000, 32'h77, 4'h1);
        cyc(); rst_n = 1'b1; drive(32'hF000_0008, 32'h0, 4'h0);
        expect_val("rst2_cycle_zero", SEL_RD, 32'd0);
        expect_val("rst2_halt", SEL_HALT, 32'd0);
        expect_val("rst2_tohost", SEL_TOHOST, 32'd0);
        expect_val("rst2_valid", SEL_VALID, 32'd0);
        cyc(); drive(32'h200, 32'h0, 4'h0);
        expect_val("rst_ram_store", SEL_RD, 32'hCAFE_F00D);
        cyc(); drive(32'hF000_0004, 32'h0, 4'h0);
        expect_val("rst2_status", SEL_RD, 32'h0000_0002);
        cyc(); drive(32'hF000_000C, 32'h0, 4'h0);
        expect_val("rst2_tohost_rd", SEL_RD, 32'd0);
        cyc();
        @(negedge clk);
        #1;
        checks++;
        if (cons_q.size() != 0) begin
            errors++;
            $display("FAIL cons_leftover: got %0d bytes undelivered expected 0", cons_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
